// File: rtl/shot_seq_multiplier_if.sv
// Start/shot control bundle between the push-button control FSM and the multiplier.
// The control side drives start and the operands; the multiplier returns status and result.
interface shot_seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  ready,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output ready,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/shot_seq_multiplier.sv
// Shift-add unsigned multiplier started by the rising edge of the level Shot signal.
// One WIDTH-cycle multiplication per accepted edge; result held until the next completion.
module shot_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  shot_seq_multiplier_if.slave  bus,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: a request is a 0->1 transition of start. It is accepted only while
  // ready=1 (IDLE); edges seen while busy or done are dropped, never queued.
  // done is a one-cycle pulse, and product is valid from that cycle until the next done.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic                 start_q;
  logic                 req;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplr;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   product_q;
  logic                 last_step;

  logic                 ready_o;
  logic                 busy_o;
  logic                 done_o;

  // start_q resets high so a Shot already asserted at reset release is not a request.
  assign req       = bus.start & ~start_q;
  assign last_step = (count == LAST);
  assign acc_next  = mplr[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        state_d = req ? RUN : IDLE;
      end
      RUN: begin
        busy_o  = 1'b1;
        state_d = last_step ? DONE : RUN;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_o = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q   <= 1'b1;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      count     <= '0;
      product_q <= '0;
    end else begin
      start_q <= bus.start;
      case (state_q)
        IDLE: begin
          if (req) begin
            mcand <= {{WIDTH{1'b0}}, bus.multiplicand};
            mplr  <= bus.multiplier;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          count <= count + CW'(1);
          if (last_step) begin
            product_q <= acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready   = ready_o;
  assign bus.busy    = busy_o;
  assign bus.done    = done_o;
  assign bus.product = product_q;
  assign dbg_state   = state_q;

endmodule
